spi_arbiter: RTL
================

# spi_arbiter

Round-robin scheduler that shares one SPI shift engine between `NREQ` requesters. It accepts one frame request per requester and grants the engine to one requester at a time. It frames each transfer with `SSB` and drives the engine through a start/done handshake. Each response returns to the requester that was granted, and the block enforces a minimum `SSB`-high guard interval between frames. It sits between on-chip clients and the SPI master shift path that drives `MOSI`/`MISO` toward the slave.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `DW`, 8: frame width in bits.
- `GUARD`, 2: `SSB`-high cycles between frames, ≥1.
- `TIMEOUT`, 64: engine watchdog limit in cycles. Used only with `SPI_ARB_TIMEOUT_EN`.

Ports (direction, width, meaning):
- `SCK`, in, 1: system clock; all logic on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `req`, in, `NREQ`: per-requester request level.
- `req_data`, in, `NREQ*DW`: TX frame of requester i in bits [i*DW +: DW].
- `gnt`, out, `NREQ`: one-hot grant pulse, one cycle long.
- `rsp_valid`, out, `NREQ`: one-hot response-valid pulse, one cycle long.
- `rsp_data`, out, `DW`: RX frame; valid while any `rsp_valid` bit is high.
- `rsp_err`, out, 1: timeout flag, qualified by `rsp_valid`.
- `eng_start`, out, 1: one-cycle start pulse to the shift engine.
- `eng_tx`, out, `DW`: frame to shift out; stable from `eng_start` until done.
- `eng_done`, in, 1: engine completion pulse.
- `eng_rx`, in, `DW`: received frame, valid with `eng_done`.
- `SSB`, out, 1: active-low slave select.
- `busy`, out, 1: high in every state except IDLE.

## Operation
- The FSM has four states: IDLE, START, WAIT and GUARD.
- IDLE:
  - If any `req` bit is set, pick a winner by round-robin, searching from `ptr` upward with wrap.
  - Latch the winner's `req_data` into `eng_tx` and its index into `cur`.
  - Go to START.
- START (always exactly 1 cycle):
  - `gnt[cur]`=1, `eng_start`=1, `SSB`=0.
  - Set `ptr` to (`cur`+1) mod `NREQ`.
  - Go to WAIT.
- WAIT:
  - `SSB`=0.
  - When `eng_done`=1, latch `eng_rx` into `rsp_data`, clear the error flag and go to GUARD.
- GUARD:
  - `SSB`=1.
  - In the first GUARD cycle only, `rsp_valid[cur]`=1.
  - After `GUARD` cycles, go to IDLE.
- Requester rules:
  - A requester holds `req` and `req_data` stable until it sees `gnt`.
  - `req` still high after `gnt` counts as a new request. It competes at the next IDLE and falls to lowest priority behind the other requesters.
- `eng_done` is ignored in IDLE, START and GUARD.
- `rsp_data` holds its value between responses.
- Reset values:
  - `gnt`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `eng_start`=0, `eng_tx`=0.
  - `SSB`=1, `busy`=0, state=IDLE, `ptr`=0, `cur`=0.
- Reset asserted mid-frame:
  - All outputs return to their reset values immediately, without waiting for a clock edge.
  - The in-flight frame is dropped and no `rsp_valid` is issued.
  - The engine is expected to be reset from the same `reset` net.

## Timing
- If `req` is sampled at edge k in IDLE:
  - `gnt`, `eng_start` and `SSB`=0 are valid after edge k, for cycle k+1.
  - WAIT begins after edge k+1.
- If `eng_done` is sampled at edge m:
  - `SSB`=1 and `rsp_valid` are high for cycle m+1.
  - The next `gnt` comes no earlier than after edge m+`GUARD`+1.
- Minimum frame-to-frame `SSB`-high time is `GUARD`+1 cycles, counting the IDLE cycle.
- Simultaneous requests are resolved in a single cycle. No requester waits more than `NREQ`−1 frames.

## Configuration
- `SPI_ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to WAIT and increments every WAIT cycle.
  - If it reaches `TIMEOUT` with no `eng_done`, the FSM goes to GUARD with `rsp_err`=1 and `rsp_data`=0.
  - `rsp_valid[cur]` still pulses, so the requester always receives a response.
  - `eng_done` arriving after the abort is ignored.
- Not defined:
  - No counter is built and `rsp_err` is tied to 0.
  - WAIT lasts until `eng_done` arrives, however long that takes.

## Test plan
- Single request:
  - Stimulus: `req`=4'b0010, `req_data[15:8]`=8'hA5, engine model returns 8'h3C after 8 cycles.
  - Required: `gnt`=4'b0010 together with `eng_start`, `eng_tx`=8'hA5, `SSB` low for 9 cycles, `rsp_valid`=4'b0010 with `rsp_data`=8'h3C.
- Round-robin:
  - Stimulus: `req`=4'b1111 held continuously.
  - Required: grant order 0,1,2,3,0. Every pair of frames is separated by ≥3 `SSB`-high cycles with `GUARD`=2.
- Re-request fairness:
  - Stimulus: requester 0 keeps `req` high after its grant; requester 2 raises `req` during requester 0's WAIT.
  - Required: the next grant goes to 2, then to 0.
- Ignored spurious done:
  - Stimulus: `eng_done` pulses in IDLE and again in GUARD.
  - Required: no `rsp_valid`, state unchanged.
- Reset mid-frame:
  - Stimulus: assert `reset` 3 cycles into WAIT.
  - Required: `SSB`=1 and `busy`=0 without waiting for a clock edge, no `rsp_valid`, first grant after reset goes to requester 0.
- Timeout (with `SPI_ARB_TIMEOUT_EN`, `TIMEOUT`=16):
  - Stimulus: engine model never asserts `eng_done`.
  - Required: `rsp_valid` with `rsp_err`=1 and `rsp_data`=0 exactly 17 cycles after `eng_start`; the next request is served normally.

Source files
------------

// File: rtl/spi_arbiter.sv
// -----------------------------------------------------------------------------
// spi_arbiter
//
// Shares one SPI shift engine between NREQ on-chip requesters. A round-robin
// search picks one pending request at a time. The block frames the transfer
// with SSB (active low), starts the engine, and returns the received frame to
// the requester that was granted. It then holds SSB high for a guard interval
// before the next frame.
//
// Optional feature macro: SPI_ARB_TIMEOUT_EN
//   When defined, an engine watchdog aborts a transfer that has not completed
//   after TIMEOUT WAIT cycles. The abort returns rsp_err=1 and rsp_data=0.
//   When undefined, no watchdog is built and rsp_err is tied low.
//
// Handshakes:
//   req/gnt      : a requester holds req and its req_data slice stable until
//                  it sees its one-cycle gnt pulse. A req still high after gnt
//                  is a fresh request and queues behind the other requesters.
//   eng_start/done: eng_start pulses for one cycle with eng_tx valid. eng_tx
//                  stays stable until eng_done. eng_done is a one-cycle pulse
//                  carrying eng_rx, and it is only honoured while waiting.
//
// Ports:
//   SCK        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   req        in   [NREQ]     request levels
//   req_data   in   [NREQ*DW]  TX frame of requester i at [i*DW +: DW]
//   gnt        out  [NREQ]     one-hot grant pulse
//   rsp_valid  out  [NREQ]     one-hot response pulse
//   rsp_data   out  [DW]       RX frame, held between responses
//   rsp_err    out            watchdog abort flag, qualified by rsp_valid
//   eng_start  out            engine start pulse
//   eng_tx     out  [DW]       frame to shift out
//   eng_done   in             engine completion pulse
//   eng_rx     in   [DW]       received frame, valid with eng_done
//   SSB        out            active-low slave select
//   busy       out            high whenever the FSM is not IDLE
//   dbg_state  out  [2]        current FSM state (0 IDLE, 1 START, 2 WAIT, 3 GUARD)
// -----------------------------------------------------------------------------
module spi_arbiter #(
   parameter int NREQ    = 4,
   parameter int DW      = 8,
   parameter int GUARD   = 2,
   parameter int TIMEOUT = 64
) (
   input  logic               SCK,
   input  logic               reset,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*DW-1:0] req_data,
   output logic [NREQ-1:0]    gnt,
   output logic [NREQ-1:0]    rsp_valid,
   output logic [DW-1:0]      rsp_data,
   output logic               rsp_err,
   output logic               eng_start,
   output logic [DW-1:0]      eng_tx,
   input  logic               eng_done,
   input  logic [DW-1:0]      eng_rx,
   output logic               SSB,
   output logic               busy,
   output logic [1:0]         dbg_state
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int GW = $clog2(GUARD + 1);

   if (NREQ < 2 || NREQ > 8 || GUARD < 1 || TIMEOUT < 1) begin : g_cfg_check
      $error("spi_arbiter: illegal parameter set");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_GUARD = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     ptr_q, ptr_d;
   logic [IW-1:0]     cur_q, cur_d;
   logic [GW-1:0]     gcnt_q, gcnt_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
   logic [DW-1:0]     rsp_data_q, rsp_data_d;
   logic              eng_start_q, eng_start_d;
   logic [DW-1:0]     eng_tx_q, eng_tx_d;
   logic              ssb_q, ssb_d;
   logic              busy_q, busy_d;

`ifdef SPI_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0]     tcnt_q, tcnt_d;
   logic              rsp_err_q, rsp_err_d;
`endif

   // Round-robin pick: first set req bit at or above ptr_q, wrapping.
   logic              win_found;
   logic [IW-1:0]     win_idx;
   logic [IW:0]       cand;

   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int i = 0; i < NREQ; i++) begin
         cand = {1'b0, ptr_q} + (IW+1)'(i);
         if (cand >= (IW+1)'(NREQ)) begin
            cand = cand - (IW+1)'(NREQ);
         end
         if (!win_found && req[cand[IW-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[IW-1:0];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      cur_d       = cur_q;
      gcnt_d      = gcnt_q;
      gnt_d       = '0;
      rsp_valid_d = '0;
      rsp_data_d  = rsp_data_q;
      eng_start_d = 1'b0;
      eng_tx_d    = eng_tx_q;
      ssb_d       = ssb_q;
`ifdef SPI_ARB_TIMEOUT_EN
      tcnt_d      = tcnt_q;
      rsp_err_d   = rsp_err_q;
`endif

      case (state_q)
         S_IDLE: begin
            ssb_d = 1'b1;
            if (win_found) begin
               cur_d          = win_idx;
               eng_tx_d       = req_data[win_idx*DW +: DW];
               gnt_d[win_idx] = 1'b1;
               eng_start_d    = 1'b1;
               ssb_d          = 1'b0;
               state_d        = S_START;
            end
         end

         S_START: begin
            // The winner drops to lowest priority for the next search.
            ptr_d   = (cur_q == IW'(NREQ - 1)) ? '0 : cur_q + 1'b1;
            ssb_d   = 1'b0;
            state_d = S_WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
            tcnt_d  = '0;
`endif
         end

         S_WAIT: begin
            ssb_d = 1'b0;
            if (eng_done) begin
               rsp_data_d         = eng_rx;
               rsp_valid_d[cur_q] = 1'b1;
               ssb_d              = 1'b1;
               gcnt_d             = '0;
               state_d            = S_GUARD;
`ifdef SPI_ARB_TIMEOUT_EN
               rsp_err_d          = 1'b0;
`endif
            end
`ifdef SPI_ARB_TIMEOUT_EN
            // tcnt_q counts completed WAIT cycles; this cycle is the
            // TIMEOUT-th one, so the watchdog fires at its end.
            else if (tcnt_q == TW'(TIMEOUT - 1)) begin
               rsp_data_d         = '0;
               rsp_err_d          = 1'b1;
               rsp_valid_d[cur_q] = 1'b1;
               ssb_d              = 1'b1;
               gcnt_d             = '0;
               state_d            = S_GUARD;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
`endif
         end

         S_GUARD: begin
            ssb_d = 1'b1;
            if (gcnt_q == GW'(GUARD - 1)) begin
               state_d = S_IDLE;
            end else begin
               gcnt_d = gcnt_q + 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
            ssb_d   = 1'b1;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge SCK or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         cur_q       <= '0;
         gcnt_q      <= '0;
         gnt_q       <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         eng_start_q <= 1'b0;
         eng_tx_q    <= '0;
         ssb_q       <= 1'b1;
         busy_q      <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
         tcnt_q      <= '0;
         rsp_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         cur_q       <= cur_d;
         gcnt_q      <= gcnt_d;
         gnt_q       <= gnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         eng_start_q <= eng_start_d;
         eng_tx_q    <= eng_tx_d;
         ssb_q       <= ssb_d;
         busy_q      <= busy_d;
`ifdef SPI_ARB_TIMEOUT_EN
         tcnt_q      <= tcnt_d;
         rsp_err_q   <= rsp_err_d;
`endif
      end
   end

   assign gnt       = gnt_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign eng_start = eng_start_q;
   assign eng_tx    = eng_tx_q;
   assign SSB       = ssb_q;
   assign busy      = busy_q;
   assign dbg_state = state_q;

`ifdef SPI_ARB_TIMEOUT_EN
   assign rsp_err = rsp_err_q;
`else
   assign rsp_err = 1'b0;
`endif

endmodule
